// File: rtl/systolic_input_loader.sv
// Receive-side operand loader: packs a 64-bit beat stream into two 512-bit blocks (A then B),
// strobes start to the controller, and holds both blocks stable until the multiply is done.
module systolic_input_loader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = 8,
  localparam int unsigned BLK_W = DATA_W * BEATS,
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              done_matrix_mult,
  output logic [BLK_W-1:0]  matrix_a,
  output logic [BLK_W-1:0]  matrix_b,
  output logic              operands_valid,
  output logic              start_matrix_mult,
  output logic [CW-1:0]     beat_count
);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      beat_q, beat_d;
  logic [BLK_W-1:0]   matrix_a_q, matrix_a_d;
  logic [BLK_W-1:0]   matrix_b_q, matrix_b_d;
  logic               src_ready_q, src_ready_d;
  logic               start_q, start_d;
  logic               operands_valid_q, operands_valid_d;

  logic               xfer;
  logic               last_beat;
  logic [CW-1:0]      slot;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    matrix_a_d = matrix_a_q;
    matrix_b_d = matrix_b_q;

    xfer      = src_valid && src_ready_q;
    last_beat = (beat_q == CW'(BEATS - 1));
    // Beat 0 lands in the most significant slot of the block.
    slot      = CW'(BEATS - 1) - beat_q;

    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          matrix_a_d[slot*DATA_W +: DATA_W] = src_data;
          beat_d = last_beat ? '0 : beat_q + CW'(1);
          if (last_beat) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (xfer) begin
          matrix_b_d[slot*DATA_W +: DATA_W] = src_data;
          beat_d = last_beat ? '0 : beat_q + CW'(1);
          if (last_beat) state_d = START;
        end
      end
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (done_matrix_mult) state_d = LOAD_A;
      default:   state_d = LOAD_A;
    endcase

    // Outputs are registered decodes of the next state so they line up with the state flop.
    src_ready_d      = (state_d == LOAD_A) || (state_d == LOAD_B);
    start_d          = (state_d == START);
    operands_valid_d = (state_d == START) || (state_d == WAIT_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= LOAD_A;
      beat_q           <= '0;
      matrix_a_q       <= '0;
      matrix_b_q       <= '0;
      src_ready_q      <= 1'b0;
      start_q          <= 1'b0;
      operands_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_q           <= beat_d;
      matrix_a_q       <= matrix_a_d;
      matrix_b_q       <= matrix_b_d;
      src_ready_q      <= src_ready_d;
      start_q          <= start_d;
      operands_valid_q <= operands_valid_d;
    end
  end

  assign src_ready         = src_ready_q;
  assign start_matrix_mult = start_q;
  assign operands_valid    = operands_valid_q;
  assign matrix_a          = matrix_a_q;
  assign matrix_b          = matrix_b_q;
  assign beat_count        = beat_q;

endmodule

// File: tb/tb_systolic_input_loader.sv
// Scoreboard bench for systolic_input_loader: expected operand pairs are queued as blocks are
// streamed in, and a monitor pops one per start strobe.
module tb_systolic_input_loader;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEATS  = 8;
  localparam int unsigned BLK_W  = DATA_W * BEATS;

  logic              clk = 1'b0;
  logic              reset;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              done_matrix_mult;
  logic [BLK_W-1:0]  matrix_a;
  logic [BLK_W-1:0]  matrix_b;
  logic              operands_valid;
  logic              start_matrix_mult;
  logic [2:0]        beat_count;

  systolic_input_loader #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk               (clk),
    .reset             (reset),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .done_matrix_mult  (done_matrix_mult),
    .matrix_a          (matrix_a),
    .matrix_b          (matrix_b),
    .operands_valid    (operands_valid),
    .start_matrix_mult (start_matrix_mult),
    .beat_count        (beat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BLK_W-1:0] a;
    logic [BLK_W-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   start_cyc = -1;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [BLK_W-1:0] act,
                              input logic [BLK_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [BLK_W-1:0] build(input logic [DATA_W-1:0] base);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < BEATS; k++) v[(BEATS-1-k)*DATA_W +: DATA_W] = base + DATA_W'(k);
    return v;
  endfunction

  // Monitor: every start strobe must match the oldest queued operand pair.
  initial begin
    exp_t e;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (start_matrix_mult) begin
        start_cyc = cyc;
        chk("start_width", BLK_W'(prev_start), '0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_start: got start with empty scoreboard, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("sb_matrix_a", matrix_a, e.a);
          chk("sb_matrix_b", matrix_b, e.b);
          chk("sb_operands_valid", BLK_W'(operands_valid), BLK_W'(1));
        end
      end
      prev_start = start_matrix_mult;
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input bit gap);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    src_valid = 1'b1;
    src_data  = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = src_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no src_ready for word %0h, expected acceptance", d);
    end
    if (gap) begin
      src_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done();
    done_matrix_mult = 1'b1;
    @(posedge clk);
    #1;
    done_matrix_mult = 1'b0;
    chk("ready_after_done", BLK_W'(src_ready), BLK_W'(1));
    chk("ov_after_done", BLK_W'(operands_valid), '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_matrix_a"}, matrix_a, '0);
    chk({tag, "_matrix_b"}, matrix_b, '0);
    chk({tag, "_beat_count"}, BLK_W'(beat_count), '0);
    chk({tag, "_operands_valid"}, BLK_W'(operands_valid), '0);
    chk({tag, "_start"}, BLK_W'(start_matrix_mult), '0);
    chk({tag, "_src_ready"}, BLK_W'(src_ready), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t             e;
    logic [BLK_W-1:0] old_a;
    logic [BLK_W-1:0] tmp;

    reset = 1'b0;
    src_valid = 1'b0;
    src_data = '0;
    done_matrix_mult = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      src_valid = 1'($urandom_range(0, 1));
      src_data  = {$urandom, $urandom};
      done_matrix_mult = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_all_zero("rst");
    end
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    done_matrix_mult = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", BLK_W'(src_ready), BLK_W'(1));
    chk("beat_after_reset", BLK_W'(beat_count), '0);

    // Back-to-back load and minimum latency.
    e.a = build(64'h0A00);
    e.b = build(64'h0B00);
    exp_q.push_back(e);
    tmp = e.a;
    chk("a_msb_beat0", BLK_W'(tmp[511:448]), BLK_W'(64'h0A00));
    chk("a_lsb_beat7", BLK_W'(tmp[63:0]), BLK_W'(64'h0A07));
    first_cyc = cyc;
    for (int k = 0; k < 8; k++) send(64'h0A00 + 64'(k), 1'b0);
    for (int k = 0; k < 8; k++) send(64'h0B00 + 64'(k), 1'b0);
    src_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("start_latency", BLK_W'(start_cyc - first_cyc + 1), BLK_W'(17));
    chk("start_one_cycle", BLK_W'(start_matrix_mult), '0);
    chk("wait_ready_low", BLK_W'(src_ready), '0);
    chk("wait_ov_high", BLK_W'(operands_valid), BLK_W'(1));
    pulse_done();

    // Stalled stream: valid toggles every cycle.
    exp_q.push_back(e);
    for (int k = 0; k < 8; k++) begin
      send(64'h0A00 + 64'(k), 1'b1);
      if (k == 2) chk("stall_beat_count", BLK_W'(beat_count), BLK_W'(3));
    end
    for (int k = 0; k < 8; k++) send(64'h0B00 + 64'(k), 1'b1);

    // Backpressure in WAIT_DONE.
    old_a = build(64'h0A00);
    src_valid = 1'b1;
    src_data  = 64'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready_low", BLK_W'(src_ready), '0);
      chk("bp_a_stable", matrix_a, old_a);
      @(posedge clk);
      #1;
    end
    pulse_done();
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    tmp = {64'hDEAD, old_a[447:0]};
    chk("bp_dead_captured", matrix_a, tmp);
    chk("bp_beat_count", BLK_W'(beat_count), BLK_W'(1));

    // Early done during LOAD_B and START must be ignored.
    e.a = build(64'h1A00);
    e.a[511:448] = 64'hDEAD;
    e.b = build(64'h1B00);
    exp_q.push_back(e);
    for (int k = 1; k < 8; k++) send(64'h1A00 + 64'(k), 1'b0);
    done_matrix_mult = 1'b1;
    for (int k = 0; k < 8; k++) send(64'h1B00 + 64'(k), 1'b0);
    src_valid = 1'b0;
    @(posedge clk);
    #1;
    done_matrix_mult = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("early_done_ready", BLK_W'(src_ready), '0);
      chk("early_done_ov", BLK_W'(operands_valid), BLK_W'(1));
      @(posedge clk);
      #1;
    end
    pulse_done();

    // Reset mid-load of B, then a clean full load.
    for (int k = 0; k < 8; k++) send(64'h2A00 + 64'(k), 1'b0);
    for (int k = 0; k < 5; k++) send(64'h2B00 + 64'(k), 1'b0);
    src_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    e.a = build(64'h3A00);
    e.b = build(64'h3B00);
    exp_q.push_back(e);
    for (int k = 0; k < 8; k++) send(64'h3A00 + 64'(k), 1'b0);
    for (int k = 0; k < 8; k++) send(64'h3B00 + 64'(k), 1'b0);
    src_valid = 1'b0;
    @(posedge clk);
    #1;
    pulse_done();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", BLK_W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
